// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter with a one-entry holding register so the producer can
// queue the next byte mid-frame and frames go out back-to-back.
module uart_tx_frame #(
  parameter int baudrate       = 115_200,
  parameter int base_clk       = 50_000_000,
  parameter int clocks_per_bit = base_clk / baudrate
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_data_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] leds
);

  localparam logic [31:0] CPB_M1 = 32'(clocks_per_bit - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        line_q, line_d;
  logic [7:0]  leds_q, leds_d;
  logic        wrap, accept, load;

  assign wrap            = (cnt_q == CPB_M1);
  assign tx_ready        = rst & ~hold_vld_q;
  assign accept          = tx_valid & tx_ready;
  assign tx_busy         = (state_q != TX_IDLE);
  assign tx_done         = (state_q == TX_STOP) & wrap;
  assign serial_data_out = line_q;
  assign leds            = leds_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    leds_d     = leds_q;
    load       = 1'b0;

    case (state_q)
      TX_IDLE: load = hold_vld_q;
      TX_START: begin
        cnt_d = cnt_q + 32'd1;
        if (wrap) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        cnt_d = cnt_q + 32'd1;
        if (wrap) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      TX_STOP: begin
        cnt_d = cnt_q + 32'd1;
        if (wrap) begin
          cnt_d = '0;
          if (hold_vld_q) load    = 1'b1;
          else            state_d = TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Load and accept are exclusive: accept needs an empty hold, load a full one.
    if (load) begin
      shift_d    = hold_q;
      leds_d     = hold_q;
      hold_vld_d = 1'b0;
      cnt_d      = '0;
      state_d    = TX_START;
    end else if (accept) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
    end

    // Line register follows the state being entered so the start bit appears
    // on the same edge that loads the byte.
    case (state_d)
      TX_START: line_d = 1'b0;
      TX_DATA:  line_d = shift_d[idx_d];
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      line_q     <= 1'b1;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      line_q     <= line_d;
      leds_q     <= leds_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level model checked every cycle on a fast
// instance (4 clocks/bit), plus directed literal checks on it and a default instance.
module tb_uart_tx_frame;

  localparam int CPB     = 4;
  localparam int DEF_CPB = 434;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, line, busy, done;
  logic [7:0] leds;
  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready, d_line, d_busy, d_done;
  logic [7:0] d_leds;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.clocks_per_bit(CPB)) u_dut (
    .clk(clk), .rst(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_data_out(line), .tx_busy(busy),
    .tx_done(done), .leds(leds)
  );

  uart_tx_frame u_def (
    .clk(clk), .rst(rst_n), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .serial_data_out(d_line), .tx_busy(d_busy),
    .tx_done(d_done), .leds(d_leds)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: position within a 10*CPB-cycle frame, or -1 when idle.
  int         m_pos  = -1;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_hold = 8'h00;
  logic       m_hv   = 1'b0;
  logic [7:0] m_leds = 8'h00;
  logic       m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  = -1;
      m_hv   = 1'b0;
      m_leds = 8'h00;
    end else begin
      m_acc = tx_valid && !m_hv;
      if (m_pos >= 0) m_pos++;
      if (m_pos == 10 * CPB) m_pos = -1;
      if (m_pos < 0 && m_hv) begin
        m_pos  = 0;
        m_byte = m_hold;
        m_leds = m_hold;
        m_hv   = 1'b0;
      end
      if (m_acc) begin
        m_hv   = 1'b1;
        m_hold = tx_data;
      end
    end
  end

  function automatic logic exp_line();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  always @(negedge clk) begin
    chk("model_line",  32'(line),     32'(exp_line()));
    chk("model_busy",  32'(busy),     32'(m_pos >= 0));
    chk("model_done",  32'(done),     32'(m_pos == 10 * CPB - 1));
    chk("model_ready", 32'(tx_ready), 32'(rst_n && !m_hv));
    chk("model_leds",  32'(leds),     32'(m_leds));
  end

  // Behavioural receivers sampling mid-bit.
  logic [7:0] rxq[$];
  logic [7:0] rxq_def[$];
  logic [7:0] dec_b, dec_d;

  initial begin
    forever begin
      @(negedge clk);
      if (line === 1'b0 && rst_n === 1'b1) begin
        repeat (CPB / 2) @(negedge clk);
        if (line === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            dec_b[i] = line;
          end
          repeat (CPB) @(negedge clk);
          if (line === 1'b1) rxq.push_back(dec_b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (d_line === 1'b0 && rst_n === 1'b1) begin
        repeat (DEF_CPB / 2) @(negedge clk);
        if (d_line === 1'b0) begin
          for (int k = 0; k < 8; k++) begin
            repeat (DEF_CPB) @(negedge clk);
            dec_d[k] = d_line;
          end
          repeat (DEF_CPB) @(negedge clk);
          if (d_line === 1'b1) rxq_def.push_back(dec_d);
        end
      end
    end
  end

  // Offers a byte and returns on the negedge just after the accepting edge.
  task automatic send(input bit def, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    if (def) begin d_data = b; d_valid = 1'b1; end
    else     begin tx_data = b; tx_valid = 1'b1; end
    while (((def ? d_ready : tx_ready) !== 1'b1) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    if (def) d_valid = 1'b0;
    else     tx_valid = 1'b0;
  endtask

  logic [9:0]  fbits;
  logic [19:0] fbits2;
  int          done_cnt, done_at, done_at2, busy_low, lows, first_high, ready_hi;

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; d_valid = 1'b0; d_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_line",  32'(line),     32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_leds",  32'(leds),     32'h00);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(tx_ready), 32'd1);

    // Single frame 0x55: {stop, data, start} hand-assembled.
    fbits = 10'b1010101010;
    send(1'b0, 8'h55);
    chk("lat_line_pre", 32'(line), 32'd1);
    done_cnt = 0; done_at = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk("f55_line", 32'(line), 32'(fbits[j/4]));
      if (done) begin done_cnt++; done_at = j; end
    end
    chk("f55_done_cnt", 32'(done_cnt), 32'd1);
    chk("f55_done_at",  32'(done_at),  32'd39);
    @(negedge clk);
    chk("f55_busy_after", 32'(busy), 32'd0);
    chk("f55_leds",       32'(leds), 32'h55);
    repeat (5) @(negedge clk);

    // Back-to-back 0xA5 then 0x3C.
    rxq.delete();
    fbits2 = {10'b1001111000, 10'b1101001010};
    send(1'b0, 8'hA5);
    done_cnt = 0; done_at = -1; done_at2 = -1; busy_low = 0; ready_hi = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (j == 0) begin
        ready_hi = tx_ready;
        tx_data = 8'h3C; tx_valid = 1'b1;
      end
      if (j == 1) tx_valid = 1'b0;
      chk("b2b_line", 32'(line), 32'(fbits2[j/4]));
      if (!busy) busy_low++;
      if (done) begin
        if (done_cnt == 0) done_at = j; else done_at2 = j;
        done_cnt++;
      end
    end
    chk("b2b_ready_rise", 32'(ready_hi), 32'd1);
    chk("b2b_busy_gap",   32'(busy_low), 32'd0);
    chk("b2b_done_cnt",   32'(done_cnt), 32'd2);
    chk("b2b_done_gap",   32'(done_at2 - done_at), 32'd40);
    repeat (5) @(negedge clk);
    chk("b2b_rx_n",  32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      chk("b2b_rx0", 32'(rxq[0]), 32'hA5);
      chk("b2b_rx1", 32'(rxq[1]), 32'h3C);
    end

    // Hold full: 0x33 offered while not ready must be dropped.
    rxq.delete();
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    tx_data = 8'h33; tx_valid = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      chk("hold_ready_low", 32'(tx_ready), 32'd0);
    end
    tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    chk("hold_rx_n", 32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      chk("hold_rx0", 32'(rxq[0]), 32'h11);
      chk("hold_rx1", 32'(rxq[1]), 32'h22);
    end
    chk("hold_leds", 32'(leds), 32'h22);
    chk("hold_idle", 32'(busy), 32'd0);

    // Reset during data bit 3 of 0xF0 with 0x77 held.
    send(1'b0, 8'hF0);
    send(1'b0, 8'h77);
    repeat (16) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_line",  32'(line),     32'd1);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_ready", 32'(tx_ready), 32'd0);
    chk("mid_rst_leds",  32'(leds),     32'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(tx_ready), 32'd1);
    lows = 0; busy_low = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (line !== 1'b1) lows++;
      if (busy !== 1'b0) busy_low++;
    end
    chk("post_rst_line_lows", 32'(lows),     32'd0);
    chk("post_rst_busy",      32'(busy_low), 32'd0);

    // Default rate, byte 0x00: 9*434 low cycles then 434 high.
    send(1'b1, 8'h00);
    lows = 0; first_high = -1; done_cnt = 0; done_at = -1;
    for (int j = 0; j < 10 * DEF_CPB; j++) begin
      @(negedge clk);
      if (d_line === 1'b0) lows++;
      else if (first_high < 0) first_high = j;
      if (d_done) begin done_cnt++; done_at = j; end
    end
    chk("def_lows",       32'(lows),       32'd3906);
    chk("def_first_high", 32'(first_high), 32'd3906);
    chk("def_done_cnt",   32'(done_cnt),   32'd1);
    chk("def_done_at",    32'(done_at),    32'd4339);
    @(negedge clk);
    chk("def_busy_after", 32'(d_busy), 32'd0);

    // Default-rate loopback of 0xC3.
    rxq_def.delete();
    send(1'b1, 8'hC3);
    repeat (10 * DEF_CPB + 10) @(negedge clk);
    chk("loop_rx_n", 32'(rxq_def.size()), 32'd1);
    if (rxq_def.size() == 1) chk("loop_rx", 32'(rxq_def[0]), 32'hC3);
    chk("loop_leds", 32'(d_leds), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
